// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read port between fetch_ctrl (master) and the memory (slave).
// One request in flight at a time; the response comes back at least one cycle later.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rsp_valid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rsp_valid, imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives the external PC register, issues single outstanding
// imem reads and handles stall and redirects. Define FETCH_MISALIGN_TRAP_EN to trap misaligned targets.
//
// state    | meaning
// ST_BOOT  | first cycle after reset, PC loads RESET_VECTOR
// ST_REQ   | read request issued for pc_curr
// ST_WAIT  | waiting for the response of the issued read
// ST_HOLD  | instruction parked in hold registers while decode stalls
// ST_DRAIN | redirected with a read in flight, discard its response
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  pc_curr,
  output logic [31:0]  pc_next,
  fetch_ctrl_if.master imem,
  output logic         inst_valid,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  input  logic         stall,
  input  logic         br_taken,
  input  logic [31:0]  br_target,
  input  logic         trap,
  input  logic [31:0]  mtvec,
  input  logic         mret,
  input  logic [31:0]  mepc,
  output logic         flush,
  output logic         misalign
);

  typedef enum logic [2:0] {ST_BOOT, ST_REQ, ST_WAIT, ST_HOLD, ST_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  logic        rsp;
  logic        redir;
  logic        redir_mis;
  logic [31:0] redir_tgt;
  logic [31:0] raw_tgt;
  logic [31:0] trap_base;

  assign rsp            = imem.imem_rsp_valid;
  assign imem.imem_addr = pc_curr;
  assign trap_base      = mtvec & 32'hFFFF_FFFC;
  // Redirects are not accepted until the reset vector has been loaded.
  assign redir          = (state_q != ST_BOOT) && (trap || mret || br_taken);

  always_comb begin
    raw_tgt   = mret ? mepc : br_target;
    redir_tgt = trap_base;
    redir_mis = 1'b0;
    if (!trap) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (raw_tgt[1:0] != 2'b00) redir_mis = 1'b1;
      else                       redir_tgt = raw_tgt;
`else
      redir_tgt = raw_tgt & 32'hFFFF_FFFC;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      hold_inst_q <= 32'h0;
      hold_pc_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    case (state_q)
      ST_BOOT:  state_d = ST_REQ;
      ST_REQ:   state_d = redir ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (redir) begin
          state_d = rsp ? ST_REQ : ST_DRAIN;
        end else if (rsp) begin
          if (stall) begin
            state_d     = ST_HOLD;
            hold_inst_d = imem.imem_rdata;
            hold_pc_d   = pc_curr;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_HOLD:  state_d = (stall && !redir) ? ST_HOLD : ST_REQ;
      ST_DRAIN: state_d = rsp ? ST_REQ : ST_DRAIN;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_next       = pc_curr;
    imem.imem_req = 1'b0;
    inst_valid    = 1'b0;
    inst          = hold_inst_q;
    inst_pc       = hold_pc_q;
    flush         = 1'b0;
    misalign      = 1'b0;
    case (state_q)
      ST_BOOT: pc_next = RESET_VECTOR;
      ST_REQ:  imem.imem_req = 1'b1;
      ST_WAIT: begin
        if (rsp) begin
          inst_valid = 1'b1;
          inst       = imem.imem_rdata;
          inst_pc    = pc_curr;
          if (!stall) pc_next = pc_curr + 32'd4;
        end
      end
      ST_HOLD: begin
        inst_valid = 1'b1;
        if (!stall) pc_next = pc_curr + 32'd4;
      end
      default: ;
    endcase
    if (redir) begin
      pc_next    = redir_tgt;
      flush      = 1'b1;
      misalign   = redir_mis;
      inst_valid = 1'b0;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_VECTOR, 32'h0000_0000, first fetch address loaded into the PC register after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pc_curr  input  32  current value of the PC register.
REQ-005 pc_next  output  32  next value for the PC register; combinational.
REQ-006 imem_req  output  1  instruction-memory read request; address is imem_addr.
REQ-007 imem_addr  output  32  fetch address; equals pc_curr.
REQ-008 imem_rsp_valid  input  1  read data valid, at least 1 cycle after request.
REQ-009 imem_rdata  input  32  instruction word, sampled when imem_rsp_valid=1.
REQ-010 inst_valid  output  1  inst and inst_pc valid for decode.
REQ-011 inst, inst_pc  output  32 each  instruction word and its address.
REQ-012 stall  input  1  decode cannot accept; hold instruction.
REQ-013 br_taken, br_target  input  1, 32  branch/jump redirect request and target.
REQ-014 trap, mtvec  input  1, 32  trap redirect request and handler base.
REQ-015 mret, mepc  input  1, 32  return redirect request and target.
REQ-016 flush  output  1  one-cycle pulse on every accepted redirect.
REQ-017 misalign  output  1  one-cycle pulse on misaligned branch/mret target.

Function
REQ-018 States: BOOT, REQ, WAIT, HOLD, DRAIN.
REQ-019 BOOT: imem_req=0, pc_next=RESET_VECTOR, redirects ignored; next state REQ.
REQ-020 REQ: imem_req=1, pc_next=pc_curr; next state WAIT; one request outstanding maximum.
REQ-021 WAIT, no rsp: imem_req=0, pc_next=pc_curr, stay WAIT.
REQ-022 WAIT, rsp, stall=0: inst_valid=1, inst=imem_rdata, inst_pc=pc_curr, pc_next=pc_curr+4 (mod 2^32 wrap), next REQ.
REQ-023 WAIT, rsp, stall=1: inst_valid=1, imem_rdata/pc_curr captured into hold registers, pc_next=pc_curr, next HOLD.
REQ-024 HOLD: inst_valid=1 from hold registers; stall=1 stays HOLD with pc_next=pc_curr; stall=0 gives pc_next=pc_curr+4, next REQ.
REQ-025 Redirect priority trap > mret > br_taken; target = mtvec with bits[1:0] forced 0, mepc, br_target respectively.
REQ-026 Redirect accepted in REQ, WAIT, HOLD, DRAIN: pc_next=target, flush=1, inst_valid=0, overrides stall.
REQ-027 Redirect in REQ, or in WAIT without rsp: next DRAIN; redirect in WAIT with rsp or in HOLD: response discarded, next REQ.
REQ-028 DRAIN: imem_req=0, inst_valid=0, pc_next=pc_curr; rsp discarded and next REQ; further redirect updates pc_next, stays DRAIN.
REQ-029 inst/inst_pc are don't-care when inst_valid=0; flush and misalign never high without an accepted redirect.

Reset
REQ-030 rst_n=0 asynchronously forces state BOOT, hold registers to 0, inst_valid=0, imem_req=0, flush=0, misalign=0.
REQ-031 Reset mid-request: any outstanding response arriving after reset release in BOOT/REQ is ignored (handled as DRAIN-equivalent discard on first rsp before next request issues).

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN defined: br/mret target with bits[1:0]!=0 gives misalign=1 and pc_next=mtvec with bits[1:0]=0, flush=1, state transitions as REQ-027.
REQ-033 Macro undefined: target bits[1:0] forced to 0, misalign tied 0.

Verification
REQ-034 Reset release, RESET_VECTOR=32'h100, memory latency 1 -> imem_addr 0x100,0x104,0x108 on successive requests, inst_valid each rsp.
REQ-035 rsp at pc 0x200 with stall high 3 cycles -> inst_valid held 4 cycles, inst constant, pc_next=0x200, then 0x204.
REQ-036 br_taken to 0x400 in WAIT, rsp 2 cycles later -> flush 1 cycle, rsp discarded (inst_valid=0), next imem_addr 0x400.
REQ-037 trap and br_taken same cycle, mtvec=0x803 -> pc_next=0x800, single flush pulse.
REQ-038 pc_curr=0xFFFF_FFFC sequential fetch -> pc_next=0x0000_0000.
REQ-039 With FETCH_MISALIGN_TRAP_EN, br_target=0x302, mtvec=0x80 -> misalign=1, pc_next=0x80; without macro -> pc_next=0x300, misalign=0.
